ts_sync_lock: RTL and testbench



---
 rtl/ts_sync_lock.sv | 155 +++++++++++++++
 tb/tb_ts_sync_lock.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_sync_lock.sv
// rtl/ts_sync_lock.sv - MPEG-TS sync byte hunter/locker feeding the 10-bit word packer
module ts_sync_lock #(
  parameter int         PKT_LEN    = 188,
  parameter logic [7:0] SYNC_BYTE  = 8'h47,
  parameter int         LOCK_COUNT = 3,
  parameter int         LOSS_COUNT = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic [9:0]  DATA_OUT,
  output logic        LOCKED,
  output logic [15:0] PKT_COUNT,
  output logic [15:0] SYNC_ERR_COUNT
);

  localparam logic [7:0] LP_LAST_POS = 8'(PKT_LEN - 1);
  localparam logic [3:0] LP_LOCK     = 4'(LOCK_COUNT);
  localparam logic [3:0] LP_LOSS     = 4'(LOSS_COUNT);

  typedef enum logic [1:0] {
    S_HUNT,
    S_VERIFY,
    S_LOCKED
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [7:0]  r_pos;
  logic [7:0]  w_pos_nx;
  logic [7:0]  w_pos_adv;
  logic [3:0]  r_good;
  logic [3:0]  w_good_nx;
  logic [3:0]  r_miss;
  logic [3:0]  w_miss_nx;
  logic        w_fwd;
  logic        w_sop;
  logic        w_err_inc;
  logic        w_is_sync;
  logic        w_at_sync_pos;
  logic [9:0]  r_data;
  logic [15:0] r_pkt_count;
  logic [15:0] r_err_count;

  assign w_is_sync     = (BYTE_IN == SYNC_BYTE);
  assign w_at_sync_pos = (r_pos == 8'd0);
  assign w_pos_adv     = (r_pos == LP_LAST_POS) ? 8'd0 : r_pos + 8'd1;

  // State, packet position and good/miss run counters
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_HUNT;
      r_pos   <= 8'd0;
      r_good  <= 4'd0;
      r_miss  <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_pos   <= w_pos_nx;
      r_good  <= w_good_nx;
      r_miss  <= w_miss_nx;
    end
  end

  // Next-state and forwarding decision for the byte presented this cycle
  always_comb begin
    w_state_nx = r_state;
    w_pos_nx   = r_pos;
    w_good_nx  = r_good;
    w_miss_nx  = r_miss;
    w_fwd      = 1'b0;
    w_sop      = 1'b0;
    w_err_inc  = 1'b0;
    if (BYTE_VALID) begin
      case (r_state)
        S_HUNT: begin
          // The sync byte just found is position 0, so the next byte is position 1
          if (w_is_sync) begin
            w_state_nx = S_VERIFY;
            w_pos_nx   = 8'd1;
            w_good_nx  = 4'd1;
          end
        end
        S_VERIFY: begin
          w_pos_nx = w_pos_adv;
          if (w_at_sync_pos) begin
            if (w_is_sync) begin
              w_good_nx = r_good + 4'd1;
              if (r_good + 4'd1 == LP_LOCK) begin
                w_state_nx = S_LOCKED;
                w_miss_nx  = 4'd0;
                w_fwd      = 1'b1;
                w_sop      = 1'b1;
              end
            end else begin
              w_state_nx = S_HUNT;
              w_good_nx  = 4'd0;
            end
          end
        end
        S_LOCKED: begin
          w_pos_nx = w_pos_adv;
          w_fwd    = 1'b1;
          if (w_at_sync_pos) begin
            w_sop = 1'b1;
            if (w_is_sync) begin
              w_miss_nx = 4'd0;
            end else begin
              w_err_inc = 1'b1;
              // Flywheel through isolated misses; the last allowed miss drops lock unforwarded
              if (r_miss + 4'd1 == LP_LOSS) begin
                w_state_nx = S_HUNT;
                w_miss_nx  = 4'd0;
                w_good_nx  = 4'd0;
                w_fwd      = 1'b0;
                w_sop      = 1'b0;
              end else begin
                w_miss_nx = r_miss + 4'd1;
              end
            end
          end
        end
        default: begin
          w_state_nx = S_HUNT;
        end
      endcase
    end
  end

  // Output word register and status counters
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_data      <= 10'd0;
      r_pkt_count <= 16'd0;
      r_err_count <= 16'd0;
    end else begin
      r_data[9:8] <= {w_sop, w_fwd};
      if (w_fwd) begin
        r_data[7:0] <= BYTE_IN;
      end
      if (w_sop) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      if (w_err_inc && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign DATA_OUT       = r_data;
  assign LOCKED         = (r_state == S_LOCKED);
  assign PKT_COUNT      = r_pkt_count;
  assign SYNC_ERR_COUNT = r_err_count;

endmodule

// File: tb/tb_ts_sync_lock.sv
// tb/tb_ts_sync_lock.sv - self-checking bench for ts_sync_lock with behavioural model
module tb_ts_sync_lock;

  localparam int         PKT_LEN = 188;
  localparam logic [7:0] SYNC    = 8'h47;
  localparam int         LOCK_N  = 3;
  localparam int         LOSS_N  = 3;

  logic        CLOCK;
  logic        RESET;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic [9:0]  DATA_OUT;
  logic        LOCKED;
  logic [15:0] PKT_COUNT;
  logic [15:0] SYNC_ERR_COUNT;

  ts_sync_lock #(
    .PKT_LEN(PKT_LEN),
    .SYNC_BYTE(SYNC),
    .LOCK_COUNT(LOCK_N),
    .LOSS_COUNT(LOSS_N)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .BYTE_IN(BYTE_IN),
    .BYTE_VALID(BYTE_VALID),
    .DATA_OUT(DATA_OUT),
    .LOCKED(LOCKED),
    .PKT_COUNT(PKT_COUNT),
    .SYNC_ERR_COUNT(SYNC_ERR_COUNT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: mode 0 = searching, 1 = confirming, 2 = locked
  int          m_mode;
  int          m_pos;
  int          m_good;
  int          m_miss;
  logic [9:0]  exp_data;
  logic        exp_locked;
  logic [15:0] exp_pkt;
  logic [15:0] exp_err;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] mdl,
                     input logic [15:0] val);
    chk(name, act, val);
    chk({name, "_model"}, mdl, val);
  endtask

  task automatic model_reset();
    m_mode     = 0;
    m_pos      = 0;
    m_good     = 0;
    m_miss     = 0;
    exp_data   = 10'd0;
    exp_locked = 1'b0;
    exp_pkt    = 16'd0;
    exp_err    = 16'd0;
  endtask

  task automatic model_step(input logic [7:0] b, input logic v);
    bit fwd;
    bit sop;
    int here;
    fwd = 1'b0;
    sop = 1'b0;
    if (v) begin
      if (m_mode == 0) begin
        if (b == SYNC) begin
          m_mode = 1;
          m_pos  = 1;
          m_good = 1;
        end
      end else begin
        here  = m_pos;
        m_pos = (m_pos + 1) % PKT_LEN;
        if (m_mode == 1) begin
          if (here == 0) begin
            if (b == SYNC) begin
              m_good = m_good + 1;
              if (m_good == LOCK_N) begin
                m_mode = 2;
                m_miss = 0;
                fwd    = 1'b1;
                sop    = 1'b1;
              end
            end else begin
              m_mode = 0;
            end
          end
        end else begin
          fwd = 1'b1;
          if (here == 0) begin
            sop = 1'b1;
            if (b == SYNC) begin
              m_miss = 0;
            end else begin
              m_miss = m_miss + 1;
              if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
              if (m_miss == LOSS_N) begin
                m_mode = 0;
                fwd    = 1'b0;
                sop    = 1'b0;
              end
            end
          end
        end
      end
    end
    exp_data[9:8] = {sop, fwd};
    if (fwd) exp_data[7:0] = b;
    if (sop) exp_pkt = exp_pkt + 16'd1;
    exp_locked = (m_mode == 2);
  endtask

  // Every-cycle comparison of the DUT against the model, half a cycle after the edge
  always @(negedge CLOCK) begin
    if (chk_en) begin
      chk("data_out", {6'd0, DATA_OUT}, {6'd0, exp_data});
      chk("locked", {15'd0, LOCKED}, {15'd0, exp_locked});
      chk("pkt_count", PKT_COUNT, exp_pkt);
      chk("sync_err_count", SYNC_ERR_COUNT, exp_err);
    end
  end

  function automatic logic [7:0] nz();
    logic [7:0] x;
    x = 8'($urandom_range(0, 255));
    if (x == SYNC) x = 8'h48;
    return x;
  endfunction

  task automatic put(input logic [7:0] b, input logic v);
    BYTE_IN    = b;
    BYTE_VALID = v;
    @(posedge CLOCK);
    model_step(b, v);
    #1;
  endtask

  task automatic do_reset();
    RESET      = 1'b1;
    BYTE_VALID = 1'b0;
    model_reset();
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic mid_reset_check(input string tag);
    RESET      = 1'b1;
    BYTE_VALID = 1'b0;
    model_reset();
    #1;
    lit({tag, "_data0"}, {6'd0, DATA_OUT}, {6'd0, exp_data}, 16'd0);
    lit({tag, "_lock0"}, {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd0);
    lit({tag, "_pkt0"}, PKT_COUNT, exp_pkt, 16'd0);
    lit({tag, "_err0"}, SYNC_ERR_COUNT, exp_err, 16'd0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
  endtask

  logic [7:0] b;
  int         p;
  int         k;
  logic       v;

  initial begin
    RESET      = 1'b1;
    BYTE_VALID = 1'b0;
    BYTE_IN    = 8'd0;
    model_reset();
    @(posedge CLOCK);
    #1;
    RESET  = 1'b0;
    chk_en = 1'b1;
    lit("reset_data", {6'd0, DATA_OUT}, {6'd0, exp_data}, 16'd0);
    lit("reset_locked", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd0);

    // Clean stream from byte 0, continuous valid
    for (int i = 0; i < PKT_LEN * 5; i++) begin
      put((i % PKT_LEN == 0) ? SYNC : nz(), 1'b1);
      if (i == 375) lit("s1_prelock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd0);
      if (i == 376) begin
        lit("s1_lock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd1);
        lit("s1_first", {6'd0, DATA_OUT}, {6'd0, exp_data}, 16'h0347);
        lit("s1_pkt", PKT_COUNT, exp_pkt, 16'd1);
      end
      if (i == 377) lit("s1_body", {14'd0, DATA_OUT[9:8]}, {14'd0, exp_data[9:8]}, 16'd1);
    end

    // 50 junk bytes, then a stream with misses, a loss and a relock
    do_reset();
    for (int i = 0; i < 50; i++) put(nz(), 1'b1);
    for (int i = 0; i < PKT_LEN * 16; i++) begin
      p = i / PKT_LEN;
      if (i % PKT_LEN == 0)
        b = (p == 5 || p == 6 || p == 9 || p == 10 || p == 11) ? 8'h00 : SYNC;
      else
        b = nz();
      put(b, 1'b1);
      if (i == 375) begin
        lit("s2_prelock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd0);
        lit("s2_prepkt", PKT_COUNT, exp_pkt, 16'd0);
      end
      if (i == 376) begin
        lit("s2_lock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd1);
        lit("s2_first", {6'd0, DATA_OUT}, {6'd0, exp_data}, 16'h0347);
      end
      if (i == PKT_LEN * 5) begin
        lit("s3_bad1", {6'd0, DATA_OUT}, {6'd0, exp_data}, 16'h0300);
        lit("s3_pkt1", PKT_COUNT, exp_pkt, 16'd4);
      end
      if (i == PKT_LEN * 6) begin
        lit("s3_bad2", {6'd0, DATA_OUT}, {6'd0, exp_data}, 16'h0300);
        lit("s3_err2", SYNC_ERR_COUNT, exp_err, 16'd2);
      end
      if (i == PKT_LEN * 8 + 1) begin
        lit("s3_held", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd1);
        lit("s3_pkt", PKT_COUNT, exp_pkt, 16'd7);
      end
      if (i == PKT_LEN * 11) begin
        lit("s4_lost", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd0);
        lit("s4_nofwd", {14'd0, DATA_OUT[9:8]}, {14'd0, exp_data[9:8]}, 16'd0);
        lit("s4_pkt", PKT_COUNT, exp_pkt, 16'd9);
        lit("s4_err", SYNC_ERR_COUNT, exp_err, 16'd5);
      end
      if (i == PKT_LEN * 14 - 1) lit("s4_prerelock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd0);
      if (i == PKT_LEN * 14) begin
        lit("s4_relock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd1);
        lit("s4_relock_pkt", PKT_COUNT, exp_pkt, 16'd10);
      end
    end

    // False sync at byte 10, true sync at byte 20
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 10 || (i >= 20 && (i - 20) % PKT_LEN == 0)) b = SYNC;
      else b = nz();
      put(b, 1'b1);
      if (i == 583) lit("s5_prelock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd0);
      if (i == 584) begin
        lit("s5_lock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd1);
        lit("s5_first", {6'd0, DATA_OUT}, {6'd0, exp_data}, 16'h0347);
      end
    end

    // Alternating valid, reset pulsed at byte 500
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      if (i == 500) mid_reset_check("s6_rst");
      put((i % PKT_LEN == 0) ? SYNC : nz(), 1'b1);
      if (i == 375) lit("s6_prelock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd0);
      if (i == 376) lit("s6_lock", {6'd0, DATA_OUT}, {6'd0, exp_data}, 16'h0347);
      if (i == 939) lit("s6_prerelock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd0);
      if (i == 940) begin
        lit("s6_relock", {15'd0, LOCKED}, {15'd0, exp_locked}, 16'd1);
        lit("s6_relock_pkt", PKT_COUNT, exp_pkt, 16'd1);
      end
      put(8'($urandom_range(0, 255)), 1'b0);
      if (i == 376) lit("s6_gap", {6'd0, DATA_OUT}, {6'd0, exp_data}, 16'h0047);
    end

    // Randomized stream: gaps, bad syncs, stray sync values, phase slips, one reset
    do_reset();
    k = 0;
    for (int n = 0; n < 8000; n++) begin
      if (n == 4000) begin
        do_reset();
        k = 0;
      end
      v = ($urandom_range(0, 3) != 0);
      if (!v) begin
        put(8'($urandom_range(0, 255)), 1'b0);
      end else if ($urandom_range(0, 499) == 0) begin
        put(8'($urandom_range(0, 255)), 1'b1);
      end else begin
        if (k == 0) b = ($urandom_range(0, 9) < 3) ? 8'h00 : SYNC;
        else b = ($urandom_range(0, 49) == 0) ? SYNC : 8'($urandom_range(0, 255));
        put(b, 1'b1);
        k = (k + 1) % PKT_LEN;
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
